floor_request_scheduler: RTL and testbench

Upstream stage of the elevator controller: captures floor-call button presses, keeps a pending-request bitmap, and presents one target floor at a time to the elevator state machine's `requested_floor` input. SCAN ordering: keep serving in the current direction until no requests remain ahead, then reverse. A request clears when the elevator reports idle at that floor. Debounced button input drives it; `current_floor`/idle from the elevator FSM feed it back.

---
 rtl/elevator_pkg.sv | 15 +
 rtl/floor_request_scheduler_button_debouncer.sv | 66 ++++++
 rtl/floor_request_scheduler.sv | 155 +++++++++++++++
 tb/tb_floor_request_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator-controller definitions: floor sizing, floor type, scheduler
// state encodings and the silicon debounce default.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS       = 10;
    localparam int unsigned FLOOR_W          = 4;
    localparam int unsigned DEBOUNCE_DEFAULT = 16;

    typedef logic [FLOOR_W-1:0] floor_t;

    localparam logic [1:0] HOLD      = 2'b00;
    localparam logic [1:0] SCAN_UP   = 2'b10;
    localparam logic [1:0] SCAN_DOWN = 2'b11;

endpackage

// File: rtl/floor_request_scheduler_button_debouncer.sv
// Synchronizes the raw call-button level and floor code, debounces the level,
// and emits a one-cycle pulse on an accepted press.
module button_debouncer
    import elevator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic   clk,
    input  logic   rst_n,
    input  floor_t btn_floor,
    input  logic   btn_press,
    output logic   press_pulse_c,
    output floor_t floor_sync
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             s1_press_q, s1_press_d;
    logic             s2_press_q, s2_press_d;
    floor_t           s1_floor_q, s1_floor_d;
    floor_t           s2_floor_q, s2_floor_d;
    logic             db_level_q, db_level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    // Counter runs only while the synchronized level disagrees with db_level.
    always_comb begin
        s1_press_d    = btn_press;
        s2_press_d    = s1_press_q;
        s1_floor_d    = btn_floor;
        s2_floor_d    = s1_floor_q;
        db_level_d    = db_level_q;
        cnt_d         = '0;
        press_pulse_c = 1'b0;
        cnt_inc       = cnt_q + CNT_W'(1);
        if (s2_press_q != db_level_q) begin
            if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
                db_level_d    = s2_press_q;
                press_pulse_c = s2_press_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_press_q <= 1'b0;
            s2_press_q <= 1'b0;
            s1_floor_q <= '0;
            s2_floor_q <= '0;
            db_level_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_press_q <= s1_press_d;
            s2_press_q <= s2_press_d;
            s1_floor_q <= s1_floor_d;
            s2_floor_q <= s2_floor_d;
            db_level_q <= db_level_d;
            cnt_q      <= cnt_d;
        end
    end

    assign floor_sync = s2_floor_q;

endmodule

// File: rtl/floor_request_scheduler.sv
// Pending floor-call bitmap with SCAN ordering; presents one registered target
// floor at a time to the elevator state machine.
module floor_request_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS      = elevator_pkg::NUM_FLOORS,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  floor_t                btn_floor,
    input  logic                  btn_press,
    input  floor_t                current_floor,
    input  logic                  elevator_idle,
    output floor_t                target_floor,
    output logic                  target_valid,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending
);

    logic                  press_pulse_c;
    floor_t                floor_sync;

    logic [1:0]            state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    floor_t                target_floor_q, target_floor_d;
    logic                  target_valid_q, target_valid_d;
    logic                  dir_up_q, dir_up_d;

    logic [NUM_FLOORS-1:0] set_mask;
    logic [NUM_FLOORS-1:0] clr_mask;
    logic                  service_c;
    logic                  any_c;
    logic                  up_hit, dn_hit;
    floor_t                up_floor, dn_floor;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_floor    (btn_floor),
        .btn_press    (btn_press),
        .press_pulse_c(press_pulse_c),
        .floor_sync   (floor_sync)
    );

    // Out-of-range floor codes never match a bitmap position, so they drop out here.
    always_comb begin
        service_c = elevator_idle && target_valid_q && (current_floor == target_floor_q);
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            set_mask[i] = press_pulse_c && (floor_sync == FLOOR_W'(i));
            clr_mask[i] = service_c && (current_floor == FLOOR_W'(i));
        end
        pending_d = (pending_q | set_mask) & ~clr_mask;
    end

    // Nearest pending floor at or above / at or below the car.
    always_comb begin
        up_hit   = 1'b0;
        up_floor = '0;
        dn_hit   = 1'b0;
        dn_floor = '0;
        for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
            if (pending_q[i] && (FLOOR_W'(i) >= current_floor)) begin
                up_hit   = 1'b1;
                up_floor = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (pending_q[i] && (FLOOR_W'(i) <= current_floor)) begin
                dn_hit   = 1'b1;
                dn_floor = FLOOR_W'(i);
            end
        end
    end

    // Reversal holds the old target for one cycle; the new direction searches next cycle.
    always_comb begin
        state_d        = state_q;
        target_floor_d = target_floor_q;
        target_valid_d = target_valid_q;
        any_c          = |pending_q;
        case (state_q)
            SCAN_UP: begin
                if (!any_c) begin
                    state_d        = HOLD;
                    target_floor_d = current_floor;
                    target_valid_d = 1'b0;
                end else if (up_hit) begin
                    target_floor_d = up_floor;
                    target_valid_d = 1'b1;
                end else begin
                    state_d        = SCAN_DOWN;
                    target_valid_d = 1'b1;
                end
            end
            SCAN_DOWN: begin
                if (!any_c) begin
                    state_d        = HOLD;
                    target_floor_d = current_floor;
                    target_valid_d = 1'b0;
                end else if (dn_hit) begin
                    target_floor_d = dn_floor;
                    target_valid_d = 1'b1;
                end else begin
                    state_d        = SCAN_UP;
                    target_valid_d = 1'b1;
                end
            end
            default: begin
                if (!any_c) begin
                    state_d        = HOLD;
                    target_floor_d = current_floor;
                    target_valid_d = 1'b0;
                end else if (up_hit) begin
                    state_d        = SCAN_UP;
                    target_floor_d = up_floor;
                    target_valid_d = 1'b1;
                end else begin
                    state_d        = SCAN_DOWN;
                    target_floor_d = dn_floor;
                    target_valid_d = 1'b1;
                end
            end
        endcase
        case (state_d)
            SCAN_UP:   dir_up_d = 1'b1;
            SCAN_DOWN: dir_up_d = 1'b0;
            default:   dir_up_d = dir_up_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= HOLD;
            pending_q      <= '0;
            target_floor_q <= '0;
            target_valid_q <= 1'b0;
            dir_up_q       <= 1'b1;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            target_floor_q <= target_floor_d;
            target_valid_q <= target_valid_d;
            dir_up_q       <= dir_up_d;
        end
    end

    assign target_floor = target_floor_q;
    assign target_valid = target_valid_q;
    assign dir_up       = dir_up_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Self-checking bench for floor_request_scheduler: directed debounce/SCAN/service
// sequences plus a randomized run against a behavioural scheduler model.
module tb_floor_request_scheduler;

    localparam int N = 10;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   btn_floor;
    logic         btn_press;
    logic [3:0]   current_floor;
    logic         elevator_idle;
    logic [3:0]   target_floor;
    logic         target_valid;
    logic         dir_up;
    logic [N-1:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    floor_request_scheduler #(
        .NUM_FLOORS     (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_floor    (btn_floor),
        .btn_press    (btn_press),
        .current_floor(current_floor),
        .elevator_idle(elevator_idle),
        .target_floor (target_floor),
        .target_valid (target_valid),
        .dir_up       (dir_up),
        .pending      (pending)
    );

    typedef struct {
        int floor;
        int hold;
        bit accepted;
    } db_vec_t;

    // Behavioural reference: synchronizer delay lines, run-length debounce, request set.
    bit  q_p[$];
    int  q_f[$];
    bit  m_db;
    int  m_run;
    bit [15:0] m_pend;
    int  m_mode;   // 0 idle, 1 scanning up, 2 scanning down
    int  m_tgt;
    bit  m_valid;
    bit  m_dir;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst_n         = 1'b0;
        btn_press     = 1'b0;
        btn_floor     = 4'd0;
        current_floor = 4'd0;
        elevator_idle = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press_floor(input int f, input int hold);
        btn_floor = 4'(f);
        btn_press = 1'b1;
        repeat (hold) @(negedge clk);
        btn_press = 1'b0;
        repeat (D + 6) @(negedge clk);
    endtask

    task automatic model_reset();
        q_p = '{0, 0};
        q_f = '{0, 0};
        m_db = 0; m_run = 0; m_pend = '0;
        m_mode = 0; m_tgt = 0; m_valid = 0; m_dir = 1;
    endtask

    task automatic model_step(input bit raw_p, input int raw_f, input int cur, input bit idle);
        bit s2p, accept, uh, dh, any;
        int s2f, up, dn;
        bit [15:0] old, nxt;
        s2p = q_p[0];
        s2f = q_f[0];
        void'(q_p.pop_front()); q_p.push_back(raw_p);
        void'(q_f.pop_front()); q_f.push_back(raw_f);
        accept = 0;
        if (s2p == m_db) m_run = 0;
        else if (m_run + 1 == D) begin m_db = s2p; m_run = 0; accept = s2p; end
        else m_run++;
        old = m_pend;
        nxt = old;
        if (accept && s2f < N) nxt[s2f] = 1'b1;
        if (idle && m_valid && cur == m_tgt && cur < N) nxt[cur] = 1'b0;
        any = (old != 0);
        uh = 0; dh = 0; up = 0; dn = 0;
        for (int f = 0; f < N; f++) begin
            if (old[f]) begin
                if (f >= cur && !uh) begin uh = 1; up = f; end
                if (f <= cur) begin dh = 1; dn = f; end
            end
        end
        if (!any) begin
            m_mode = 0; m_tgt = cur; m_valid = 0;
        end else if (m_mode == 0) begin
            m_mode = uh ? 1 : 2; m_tgt = uh ? up : dn; m_valid = 1;
        end else if (m_mode == 1) begin
            if (uh) m_tgt = up; else m_mode = 2;
            m_valid = 1;
        end else begin
            if (dh) m_tgt = dn; else m_mode = 1;
            m_valid = 1;
        end
        if (m_mode == 1) m_dir = 1;
        else if (m_mode == 2) m_dir = 0;
        m_pend = nxt;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        db_vec_t vecs[6];
        int el_cur, move_cnt, press_left, gap_left;
        bit el_idle;

        vecs[0] = '{floor: 5,  hold: 3,  accepted: 1'b0};
        vecs[1] = '{floor: 5,  hold: 4,  accepted: 1'b1};
        vecs[2] = '{floor: 0,  hold: 10, accepted: 1'b1};
        vecs[3] = '{floor: 9,  hold: 6,  accepted: 1'b1};
        vecs[4] = '{floor: 12, hold: 10, accepted: 1'b0};
        vecs[5] = '{floor: 15, hold: 8,  accepted: 1'b0};

        // Reset values
        reset_dut();
        check("reset_pending", 32'(pending), 32'd0);
        check("reset_target", 32'(target_floor), 32'd0);
        check("reset_valid", 32'(target_valid), 32'd0);
        check("reset_dir", 32'(dir_up), 32'd1);

        // Debounce table: short bounces and out-of-range floors are dropped
        foreach (vecs[i]) begin
            reset_dut();
            press_floor(vecs[i].floor, vecs[i].hold);
            check($sformatf("debounce_vec%0d", i), 32'(pending),
                  vecs[i].accepted ? (32'd1 << vecs[i].floor) : 32'd0);
        end

        // Press latency: bit appears exactly after edge D+1
        reset_dut();
        btn_floor = 4'd5;
        btn_press = 1'b1;
        for (int k = 0; k <= D + 2; k++) begin
            @(negedge clk);
            check($sformatf("latency_edge%0d", k), 32'(pending), (k >= D + 1) ? 32'h20 : 32'h0);
        end
        btn_press = 1'b0;

        // SCAN order from floor 3 going up with requests {6,8,1}
        reset_dut();
        current_floor = 4'd3;
        press_floor(6, 6);
        press_floor(8, 6);
        press_floor(1, 6);
        check("scan_pending", 32'(pending), 32'h142);
        check("scan_first_target", 32'(target_floor), 32'd6);
        check("scan_first_dir", 32'(dir_up), 32'd1);
        current_floor = 4'd6; elevator_idle = 1'b1;
        @(negedge clk);
        check("serve6_pending", 32'(pending), 32'h102);
        check("serve6_target_held", 32'(target_floor), 32'd6);
        elevator_idle = 1'b0;
        @(negedge clk);
        check("serve6_next_target", 32'(target_floor), 32'd8);
        current_floor = 4'd8; elevator_idle = 1'b1;
        @(negedge clk);
        check("serve8_pending", 32'(pending), 32'h002);
        check("serve8_dir_before", 32'(dir_up), 32'd1);
        elevator_idle = 1'b0;
        @(negedge clk);
        check("reverse_dir", 32'(dir_up), 32'd0);
        check("reverse_valid", 32'(target_valid), 32'd1);
        @(negedge clk);
        check("reverse_target", 32'(target_floor), 32'd1);
        current_floor = 4'd1; elevator_idle = 1'b1;
        @(negedge clk);
        check("serve1_pending", 32'(pending), 32'h0);
        @(negedge clk);
        check("empty_valid", 32'(target_valid), 32'd0);
        check("empty_target", 32'(target_floor), 32'd1);
        check("empty_dir_retained", 32'(dir_up), 32'd0);

        // Collision: acceptance of floor 4 on the same edge it is serviced
        reset_dut();
        current_floor = 4'd4;
        press_floor(4, 6);
        check("collide_setup_pending", 32'(pending), 32'h010);
        check("collide_setup_target", 32'(target_floor), 32'd4);
        btn_floor = 4'd4;
        btn_press = 1'b1;
        repeat (D + 1) @(negedge clk);
        elevator_idle = 1'b1;
        @(negedge clk);
        check("collide_clear_wins", 32'(pending), 32'h0);
        elevator_idle = 1'b0;
        btn_press = 1'b0;
        @(negedge clk);
        check("collide_valid", 32'(target_valid), 32'd0);
        check("collide_target", 32'(target_floor), 32'd4);
        repeat (D + 6) @(negedge clk);

        // Asynchronous reset mid-scan with three requests pending
        reset_dut();
        current_floor = 4'd5;
        press_floor(7, 6);
        press_floor(2, 6);
        press_floor(9, 6);
        check("prereset_pending", 32'(pending), 32'h284);
        check("prereset_target", 32'(target_floor), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_pending", 32'(pending), 32'd0);
        check("async_reset_target", 32'(target_floor), 32'd0);
        check("async_reset_valid", 32'(target_valid), 32'd0);
        check("async_reset_dir", 32'(dir_up), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        current_floor = 4'd0;
        repeat (3) @(negedge clk);
        check("postreset_pending", 32'(pending), 32'd0);
        check("postreset_valid", 32'(target_valid), 32'd0);

        // Randomized run with a simple car model, compared every cycle
        reset_dut();
        model_reset();
        el_cur = 0; el_idle = 0; move_cnt = 0; press_left = 0; gap_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rand_pending", 32'(pending), 32'(m_pend[N-1:0]));
            check("rand_target", 32'(target_floor), 32'(m_tgt));
            check("rand_valid", 32'(target_valid), 32'(m_valid));
            check("rand_dir", 32'(dir_up), 32'(m_dir));
            if (m_valid && el_cur != m_tgt) begin
                el_idle = 0;
                move_cnt++;
                if (move_cnt == 3) begin
                    move_cnt = 0;
                    el_cur = (m_tgt > el_cur) ? el_cur + 1 : el_cur - 1;
                end
            end else begin
                move_cnt = 0;
                el_idle = ($urandom_range(0, 3) != 0);
            end
            if (gap_left > 0) begin
                gap_left--;
                btn_press = 1'b0;
            end else if (press_left > 0) begin
                press_left--;
                btn_press = 1'b1;
                if (press_left == 0) gap_left = $urandom_range(2, 12);
            end else begin
                btn_floor  = 4'($urandom_range(0, 15));
                press_left = $urandom_range(1, 9);
                btn_press  = 1'b1;
                press_left--;
                if (press_left == 0) gap_left = $urandom_range(2, 12);
            end
            current_floor = 4'(el_cur);
            elevator_idle = el_idle;
            model_step(btn_press, int'(btn_floor), el_cur, el_idle);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
